sisc_seq: RTL and testbench
===========================

# sisc_seq

Multi-cycle instruction sequencer for the sisc processor. It steps each instruction from instruction memory through fetch, decode, execute, memory and writeback, and drives every datapath control line: program counter, instruction register load, register file, ALU, status register, branch unit and data memory write. It replaces the single-state control in the sisc top level. Its inputs are the IR opcode and mask fields and the status-register output.

## Interface
Parameters:
- none

Ports:
- `CLK`  input  1  system clock; all state changes on the rising edge
- `RST_F`  input  1  reset, synchronous, active-low
- `OPCODE`  input  4  `IR[31:28]`
- `MM`  input  4  `IR[27:24]`, branch condition mask
- `STAT`  input  4  status register output
- `PC_RST`  output  1  reset program counter
- `PC_WRITE`  output  1  program counter load enable
- `PC_SEL`  output  1  0 = increment, 1 = branch address
- `BR_SEL`  output  1  0 = relative (pc_inc + imm), 1 = absolute (imm)
- `IR_LOAD`  output  1  instruction register load enable
- `RF_WE`  output  1  register file write enable
- `RD_SEL`  output  1  0 = destination `IR[15:12]`, 1 = destination `IR[19:16]`
- `ALU_OP`  output  2  00 = reg-reg, 01 = reg-imm, 10 = address add (rsa + imm), 11 = idle
- `WB_SEL`  output  1  0 = memory data, 1 = ALU result
- `STAT_EN`  output  1  status register update enable
- `DM_WE`  output  1  data memory write enable
- `HALTED`  output  1  sequencer is in HALT
- `RETIRE_CNT`  output  16  retired-instruction count; present only with `SISC_RETIRE_CNT_EN`

## Operation
Opcodes:
- 0000 NOP
- 0001 ALU reg-reg
- 0010 ALU reg-imm
- 0100 BRR (relative branch)
- 0101 BRA (absolute branch)
- 1000 LOAD
- 1001 STORE
- 1111 HALT
- Any other value executes as NOP.

States and transitions:
- START → FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH.
- From DECODE, HALT goes to HALT.
- HALT is absorbing; only reset leaves it.

Outputs are decoded from the state register and `OPCODE`. `OPCODE` is stable from DECODE onward because the IR loads only in FETCH. Any output not listed for a state is 0.

- START: `PC_RST` = 1.
- FETCH: `IR_LOAD` = 1, `PC_WRITE` = 1, `PC_SEL` = 0.
- EXECUTE:
  - ALU reg-reg: `ALU_OP` = 00, `STAT_EN` = 1.
  - ALU reg-imm: `ALU_OP` = 01, `STAT_EN` = 1.
  - LOAD/STORE: `ALU_OP` = 10.
  - All others: `ALU_OP` = 11.
- MEM:
  - STORE: `ALU_OP` = 10, `DM_WE` = 1.
  - BRR/BRA, if taken: `PC_WRITE` = 1, `PC_SEL` = 1; `BR_SEL` = 0 for BRR, 1 for BRA.
  - Branch taken rule: `MM` = 0000 is always taken; otherwise taken when `(MM & STAT) != 0`.
  - `STAT` is sampled in the MEM cycle.
- WRITEBACK:
  - ALU ops: `RF_WE` = 1, `WB_SEL` = 1, `RD_SEL` = 0, `ALU_OP` held at its EXECUTE value.
  - LOAD: `RF_WE` = 1, `WB_SEL` = 0, `RD_SEL` = 1, `ALU_OP` = 10.
- HALT: `HALTED` = 1, all other outputs 0.

## Timing
- Reset: while `RST_F` = 0 at a rising edge, the state becomes START.
- In START: `PC_RST` = 1; all other outputs 0; `RETIRE_CNT` = 0.
- First edge with `RST_F` = 1 moves START → FETCH.
- Latency: every non-HALT instruction takes exactly 5 cycles (FETCH to WRITEBACK); the next FETCH follows immediately.
- HALT enters HALT on the cycle after DECODE (3 cycles from FETCH).
- Each enable (`PC_WRITE`, `IR_LOAD`, `RF_WE`, `STAT_EN`, `DM_WE`) is high for at most one cycle per state visit.
- `PC_WRITE` is never asserted twice within one instruction except FETCH plus a taken branch in MEM.
- Reset mid-instruction, in any state including HALT: the next edge forces START, and all enables drop in that cycle. A partially executed STORE or LOAD is abandoned with no `DM_WE`/`RF_WE` after the reset edge.
- `STAT` changes during EXECUTE affect only the MEM branch decision of the following instruction, never the current EXECUTE cycle.

## Configuration
- `SISC_RETIRE_CNT_EN` defined:
  - The `RETIRE_CNT` port exists.
  - It increments by 1 on each WRITEBACK → FETCH transition.
  - It wraps from 16'hFFFF to 16'h0000.
  - It clears on reset and holds in HALT.
- `SISC_RETIRE_CNT_EN` undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset: hold `RST_F` = 0 for 3 cycles → `PC_RST` = 1, all other outputs 0. Release → next cycle FETCH with `IR_LOAD` = 1, `PC_WRITE` = 1, `PC_SEL` = 0.
- `OPCODE` = 0001:
  - `STAT_EN` = 1 and `ALU_OP` = 00 in cycle 3.
  - `RF_WE` = 1, `WB_SEL` = 1, `RD_SEL` = 0 in cycle 5.
  - Next FETCH in cycle 6.
  - `RETIRE_CNT` goes 0 → 1.
- BRR with `MM` = 0100:
  - `STAT` = 0100 → MEM shows `PC_WRITE` = 1, `PC_SEL` = 1, `BR_SEL` = 0.
  - `STAT` = 0010 → MEM shows `PC_WRITE` = 0.
  - BRA with `MM` = 0000 → taken with `BR_SEL` = 1.
- STORE → `DM_WE` = 1 only in cycle 4, `ALU_OP` = 10 in cycles 3–4, `RF_WE` never high.
- LOAD → `RF_WE` = 1, `WB_SEL` = 0, `RD_SEL` = 1 in cycle 5.
- HALT → `HALTED` = 1 from cycle 3. All enables stay 0 and `RETIRE_CNT` stays frozen for 20 cycles. Pulsing `RST_F` low returns to START, then FETCH.
- Reset asserted during the MEM cycle of a STORE → `DM_WE` = 0 in the following cycle, state START, `PC_RST` = 1.

Source files
------------

// File: rtl/sisc_seq.sv
// Multi-cycle control sequencer for sisc: 5 cycles per instruction (FETCH..WRITEBACK), HALT absorbing.
// No backpressure; outputs decode from state and OPCODE. SISC_RETIRE_CNT_EN adds the RETIRE_CNT counter.
module sisc_seq (
    input  logic        CLK,
    input  logic        RST_F,
    input  logic [3:0]  OPCODE,
    input  logic [3:0]  MM,
    input  logic [3:0]  STAT,
    output logic        PC_RST,
    output logic        PC_WRITE,
    output logic        PC_SEL,
    output logic        BR_SEL,
    output logic        IR_LOAD,
    output logic        RF_WE,
    output logic        RD_SEL,
    output logic [1:0]  ALU_OP,
    output logic        WB_SEL,
    output logic        STAT_EN,
    output logic        DM_WE,
    output logic        HALTED
`ifdef SISC_RETIRE_CNT_EN
    ,
    output logic [15:0] RETIRE_CNT
`endif
);

    localparam logic [3:0] OP_ALU_RR = 4'b0001;
    localparam logic [3:0] OP_ALU_RI = 4'b0010;
    localparam logic [3:0] OP_BRR    = 4'b0100;
    localparam logic [3:0] OP_BRA    = 4'b0101;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_STORE  = 4'b1001;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   br_taken;

    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:     state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE:    state_d = (OPCODE == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_d = S_MEM;
            S_MEM:       state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_START;
        endcase
    end

    // A zero mask means an unconditional branch.
    assign br_taken = (MM == 4'b0000) || ((MM & STAT) != 4'b0000);

    always_comb begin
        PC_RST   = 1'b0;
        PC_WRITE = 1'b0;
        PC_SEL   = 1'b0;
        BR_SEL   = 1'b0;
        IR_LOAD  = 1'b0;
        RF_WE    = 1'b0;
        RD_SEL   = 1'b0;
        ALU_OP   = 2'b00;
        WB_SEL   = 1'b0;
        STAT_EN  = 1'b0;
        DM_WE    = 1'b0;
        HALTED   = 1'b0;
        case (state_q)
            S_START: PC_RST = 1'b1;
            S_FETCH: begin
                IR_LOAD  = 1'b1;
                PC_WRITE = 1'b1;
            end
            S_EXECUTE: begin
                case (OPCODE)
                    OP_ALU_RR: STAT_EN = 1'b1;
                    OP_ALU_RI: begin
                        ALU_OP  = 2'b01;
                        STAT_EN = 1'b1;
                    end
                    OP_LOAD, OP_STORE: ALU_OP = 2'b10;
                    default:           ALU_OP = 2'b11;
                endcase
            end
            S_MEM: begin
                if (OPCODE == OP_STORE) begin
                    ALU_OP = 2'b10;
                    DM_WE  = 1'b1;
                end else if ((OPCODE == OP_BRR || OPCODE == OP_BRA) && br_taken) begin
                    PC_WRITE = 1'b1;
                    PC_SEL   = 1'b1;
                    BR_SEL   = (OPCODE == OP_BRA);
                end
            end
            S_WRITEBACK: begin
                case (OPCODE)
                    OP_ALU_RR: begin
                        RF_WE  = 1'b1;
                        WB_SEL = 1'b1;
                    end
                    OP_ALU_RI: begin
                        RF_WE  = 1'b1;
                        WB_SEL = 1'b1;
                        ALU_OP = 2'b01;
                    end
                    OP_LOAD: begin
                        RF_WE  = 1'b1;
                        RD_SEL = 1'b1;
                        ALU_OP = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_HALT:  HALTED = 1'b1;
            default: ;
        endcase
    end

`ifdef SISC_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // WRITEBACK always hands over to FETCH, so counting WRITEBACK cycles counts retirements.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_q == S_WRITEBACK) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            retire_cnt_q <= 16'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign RETIRE_CNT = retire_cnt_q;
`endif

endmodule

// File: tb/tb_sisc_seq.sv
// Scoreboard bench for sisc_seq: stimulus pushes expected per-cycle controls, a negedge monitor pops and compares.
module tb_sisc_seq;

    logic        CLK = 1'b0;
    logic        RST_F;
    logic [3:0]  OPCODE, MM, STAT;
    logic        PC_RST, PC_WRITE, PC_SEL, BR_SEL, IR_LOAD, RF_WE, RD_SEL;
    logic [1:0]  ALU_OP;
    logic        WB_SEL, STAT_EN, DM_WE, HALTED;
`ifdef SISC_RETIRE_CNT_EN
    logic [15:0] RETIRE_CNT;
`endif

    always #5 CLK = ~CLK;

    sisc_seq dut (
        .CLK(CLK), .RST_F(RST_F), .OPCODE(OPCODE), .MM(MM), .STAT(STAT),
        .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL),
        .IR_LOAD(IR_LOAD), .RF_WE(RF_WE), .RD_SEL(RD_SEL), .ALU_OP(ALU_OP),
        .WB_SEL(WB_SEL), .STAT_EN(STAT_EN), .DM_WE(DM_WE), .HALTED(HALTED)
`ifdef SISC_RETIRE_CNT_EN
        , .RETIRE_CNT(RETIRE_CNT)
`endif
    );

    // Phases of one instruction as seen by the model.
    localparam int PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_MEM = 4, PH_WB = 5;

    // {pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, rd_sel, alu_op[1:0], wb_sel, stat_en, dm_we, halted}
    localparam logic [12:0] V_START  = 13'b1_0000_0000_0000;
    localparam logic [12:0] V_HALTED = 13'b0_0000_0000_0001;

    logic [28:0] sb_q[$];
    logic [15:0] exp_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [12:0] pack(bit pc_write, bit pc_sel, bit br_sel, bit ir_load,
                                         bit rf_we, bit rd_sel, bit [1:0] alu, bit wb_sel,
                                         bit stat_en, bit dm_we);
        return {1'b0, pc_write, pc_sel, br_sel, ir_load, rf_we, rd_sel, alu, wb_sel, stat_en, dm_we, 1'b0};
    endfunction

    // Expected controls for a given instruction phase, straight from the opcode table.
    function automatic logic [12:0] model(int ph, logic [3:0] op, logic [3:0] mm, logic [3:0] stat);
        bit is_rr  = (op == 4'd1);
        bit is_ri  = (op == 4'd2);
        bit is_br  = (op == 4'd4) || (op == 4'd5);
        bit is_ld  = (op == 4'd8);
        bit is_st  = (op == 4'd9);
        bit taken  = (mm == 4'd0) || ((mm & stat) != 4'd0);
        case (ph)
            PH_FETCH: return pack(1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0);
            PH_EXEC: begin
                if (is_rr) return pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0);
                if (is_ri) return pack(0, 0, 0, 0, 0, 0, 2'd1, 0, 1, 0);
                if (is_ld || is_st) return pack(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0);
                return pack(0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0);
            end
            PH_MEM: begin
                if (is_st) return pack(0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1);
                if (is_br && taken) return pack(1, 1, op == 4'd5, 0, 0, 0, 2'd0, 0, 0, 0);
                return 13'd0;
            end
            PH_WB: begin
                if (is_rr) return pack(0, 0, 0, 0, 1, 0, 2'd0, 1, 0, 0);
                if (is_ri) return pack(0, 0, 0, 0, 1, 0, 2'd1, 1, 0, 0);
                if (is_ld) return pack(0, 0, 0, 0, 1, 1, 2'd2, 0, 0, 0);
                return 13'd0;
            end
            default: return 13'd0;
        endcase
    endfunction

    task automatic step(input logic [12:0] v);
        sb_q.push_back({exp_cnt, v});
        @(posedge CLK);
        #1;
    endtask

    // abort_ph != 0 drives RST_F low during that phase; the next cycle must be START.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat_mem,
                             input int abort_ph);
        bit aborted = 0;
        for (int ph = PH_FETCH; ph <= PH_WB && !aborted; ph++) begin
            OPCODE = (ph == PH_FETCH) ? 4'($urandom_range(0, 15)) : op;
            MM     = mm;
            STAT   = (ph == PH_MEM) ? stat_mem : 4'($urandom_range(0, 15));
            RST_F  = (ph == abort_ph) ? 1'b0 : 1'b1;
            step(model(ph, op, mm, STAT));
            if (ph == abort_ph) begin
                aborted = 1;
                RST_F   = 1'b1;
                exp_cnt = 16'd0;
                step(V_START);
            end
        end
        if (!aborted) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic run_halt();
        RST_F  = 1'b1;
        OPCODE = 4'($urandom_range(0, 15));
        step(model(PH_FETCH, 4'hF, MM, STAT));
        OPCODE = 4'hF;
        step(13'd0);
        for (int i = 0; i < 20; i++) begin
            MM   = 4'($urandom_range(0, 15));
            STAT = 4'($urandom_range(0, 15));
            step(V_HALTED);
        end
        RST_F = 1'b0;
        step(V_HALTED);
        RST_F   = 1'b1;
        exp_cnt = 16'd0;
        step(V_START);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() != 0) begin
            logic [28:0] e;
            logic [12:0] got;
            e   = sb_q.pop_front();
            got = {PC_RST, PC_WRITE, PC_SEL, BR_SEL, IR_LOAD, RF_WE, RD_SEL, ALU_OP,
                   WB_SEL, STAT_EN, DM_WE, HALTED};
            n_cmp++;
            if (got !== e[12:0]) begin
                n_bad++;
                $display("FAIL ctrl t=%0t op=%h mm=%b stat=%b got=%b exp=%b",
                         $time, OPCODE, MM, STAT, got, e[12:0]);
            end
`ifdef SISC_RETIRE_CNT_EN
            n_cmp++;
            if (RETIRE_CNT !== e[28:13]) begin
                n_bad++;
                $display("FAIL retire_cnt t=%0t got=%0d exp=%0d", $time, RETIRE_CNT, e[28:13]);
            end
`endif
        end
    end

    initial begin
        logic [3:0] ops[12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd3, 4'd6, 4'd7, 4'd10, 4'd14};
        logic [3:0] op, mm;
        int         ab;

        RST_F   = 1'b0;
        OPCODE  = 4'd0;
        MM      = 4'd0;
        STAT    = 4'd0;
        exp_cnt = 16'd0;
        @(posedge CLK);
        #1;
        repeat (3) step(V_START);
        RST_F = 1'b1;
        step(V_START);

        run_instr(4'd1, 4'd3, 4'd5, 0);
        run_instr(4'd4, 4'b0100, 4'b0100, 0);
        run_instr(4'd4, 4'b0100, 4'b0010, 0);
        run_instr(4'd5, 4'b0000, 4'b0000, 0);
        run_instr(4'd9, 4'd0, 4'd0, 0);
        run_instr(4'd8, 4'd0, 4'd0, 0);
        run_instr(4'd2, 4'd1, 4'd1, 0);
        run_instr(4'd9, 4'd0, 4'd0, PH_MEM);
        run_instr(4'd8, 4'd0, 4'd0, PH_WB);
        run_halt();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                run_halt();
            end else begin
                op = ops[$urandom_range(0, 11)];
                mm = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                ab = ($urandom_range(0, 19) == 0) ? $urandom_range(PH_FETCH, PH_WB) : 0;
                run_instr(op, mm, 4'($urandom_range(0, 15)), ab);
            end
        end

        for (int w = 0; w < 4 && sb_q.size() != 0; w++) @(posedge CLK);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d exp=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
